spawnin_queue_arbiter: RTL

Shares the single port of the SpawnInQueue BRAM between NUM_REQ requesters. Typical requesters are the spawn-in reader FSM and a queue-reset/sweeper engine. Arbitration is round-robin with a lock, so one requester's multi-access sequence (read header, clear valid, read TIDs) is atomic. The block sits between the requesters and the BRAM port; read data returns one cycle after each access and is steered to the issuing requester.

---
 rtl/spawnin_queue_arbiter_pkg.sv | 21 ++
 rtl/spawnin_queue_arbiter_rr_picker.sv | 34 +++
 rtl/spawnin_queue_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/spawnin_queue_arbiter_pkg.sv
// spawnin_queue_arbiter_pkg
//   Shared constants and types for the SpawnInQueue port arbiter.
//   SPAWNIN_ADDR_W / SPAWNIN_DATA_W : default BRAM port geometry
//   arb_state_t                     : arbiter FSM state (IDLE, OWNED)
//   idx_width()                     : width of a requester index (min 1 bit)
package spawnin_queue_arbiter_pkg;

  localparam int SPAWNIN_ADDR_W = 32;
  localparam int SPAWNIN_DATA_W = 64;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // A single requester still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spawnin_queue_arbiter_rr_picker.sv
// spawnin_queue_arbiter_rr_picker
//   Combinational round-robin search: returns the first set bit of req,
//   scanning ptr, ptr+1, ... modulo NUM_REQ.
//   req   : request vector
//   ptr   : index with highest priority
//   found : at least one request is set
//   sel   : selected index (0 when nothing is found)
module spawnin_queue_arbiter_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   sel
);

  int j;

  // Scan from the farthest position down to ptr so the closest hit wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        found = 1'b1;
        sel   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/spawnin_queue_arbiter.sv
// spawnin_queue_arbiter
//   Shares the single SpawnInQueue BRAM port between NUM_REQ requesters with
//   round-robin arbitration and a per-requester lock that keeps the grant
//   across a multi-access sequence.
//   Handshake: requester i accesses the memory in every cycle where
//   gnt[i] & req[i]; req/addr/we/din are held stable until granted. The
//   access returns dout_valid[i] (with dout) exactly one cycle later. The
//   grant is released at the end of any owned cycle with lock[owner]=0.
//   clk, rstn            : clock, synchronous active-low reset
//   req, lock            : per-requester request / keep-grant
//   addr, we, din        : packed per-requester access fields
//   gnt                  : registered one-hot grant
//   dout, dout_valid     : shared read data, per-requester data-valid
//   mem_*                : BRAM port (mem_dout has 1-cycle latency)
module spawnin_queue_arbiter
  import spawnin_queue_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = SPAWNIN_ADDR_W,
  parameter int DATA_W  = SPAWNIN_DATA_W
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          lock,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr,
  input  logic [NUM_REQ*DATA_W/8-1:0] we,
  input  logic [NUM_REQ*DATA_W-1:0]   din,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]          dout,
  output logic [NUM_REQ-1:0]          dout_valid,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                        mem_en,
  output logic [DATA_W/8-1:0]        mem_we,
  output logic [DATA_W-1:0]          mem_din,
  input  logic [DATA_W-1:0]          mem_dout,
  output logic                        mem_clk,
  output logic                        mem_rst
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int BE_W  = DATA_W / 8;

  arb_state_t         state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   owner_inc;
  logic [IDX_W-1:0]   rr_ptr;
  logic               held;
  logic [NUM_REQ-1:0] pick_req;
  logic [IDX_W-1:0]   pick_ptr;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_sel;
  logic [NUM_REQ-1:0] pick_onehot;

  assign mem_clk = clk;
  assign mem_rst = 1'b0;
  assign dout    = mem_dout;

  assign owner_inc = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign held      = |(lock & gnt);

  // In the release cycle the owner is masked and the scan starts after it,
  // so a waiting requester gets the next grant without a bubble.
  assign pick_req = (state == OWNED) ? (req & ~gnt) : req;
  assign pick_ptr = (state == OWNED) ? owner_inc : rr_ptr;

  spawnin_queue_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .sel   (pick_sel)
  );

  always_comb begin
    pick_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_onehot[i] = (pick_sel == IDX_W'(i));
    end
  end

  // Memory port mux: only a granted, requesting requester reaches the BRAM.
  always_comb begin
    mem_en   = 1'b0;
    mem_addr = '0;
    mem_we   = '0;
    mem_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i] && req[i]) begin
        mem_en   = 1'b1;
        mem_addr = addr[i*ADDR_W +: ADDR_W];
        mem_we   = we[i*BE_W +: BE_W];
        mem_din  = din[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      gnt        <= '0;
      dout_valid <= '0;
    end else begin
      dout_valid <= gnt & req;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state <= OWNED;
            owner <= pick_sel;
            gnt   <= pick_onehot;
          end
        end
        OWNED: begin
          if (!held) begin
            rr_ptr <= owner_inc;
            if (pick_found) begin
              owner <= pick_sel;
              gnt   <= pick_onehot;
            end else begin
              state <= IDLE;
              gnt   <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule
